ws2812_frame_ctrl: RTL and testbench
====================================

# ws2812_frame_ctrl

Frame scheduler for a WS2812 LED chain. Holds a double-buffered pixel store written by the host and streams one 24-bit GRB word per LED to the bit serializer over a valid/ready handshake. Enforces the latch (reset-low) gap after every frame and re-sends the displayed frame on a fixed refresh period. Sits between host/application logic and the WS2812 bit-level serializer.

## Interface

- CLK_FRE, 50, clock frequency in MHz
- LED_NUM, 8, LEDs in the chain (≥1)
- RESET_US, 300, latch gap in µs; RESET_CYC = CLK_FRE*RESET_US
- REFRESH_MS, 200, auto re-send period in ms; REFRESH_CYC = CLK_FRE*1000*REFRESH_MS
- AW, $clog2(LED_NUM) (min 1), pixel address width

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write one pixel into the back bank
- wr_addr  in  AW  pixel index; writes with wr_addr ≥ LED_NUM are ignored
- wr_data  in  24  GRB colour, bit 23 sent first
- commit  in  1  one-cycle request: display the back bank
- pix_valid  out  1  pixel word presented to the serializer
- pix_data  out  24  current pixel word
- pix_last  out  1  high with the last pixel (index LED_NUM-1)
- pix_ready  in  1  serializer accepts pix_data this cycle
- ser_idle  in  1  serializer has finished shifting all accepted bits
- busy  out  1  high in every state except IDLE and HOLD
- frame_done  out  1  one-cycle pulse at the end of the latch gap

## Operation

- Two banks of LED_NUM×24 bits; front_sel selects the bank being sent. Writes always go to the back bank (!front_sel) and never alter the frame in flight.
- commit sets commit_pend, which stays set until a swap consumes it. Repeated commits before the swap collapse into one.
- States:
  - IDLE: if commit_pend, toggle front_sel, clear commit_pend, go to FETCH.
  - FETCH: issue a read of pixel 0 from the front bank; go to SEND.
  - SEND: pix_valid=1. On pix_valid&&pix_ready, advance the index and present the next word. After the transfer with pix_last, go to DRAIN.
  - DRAIN: wait for ser_idle=1, then go to LATCH.
  - LATCH: count RESET_CYC cycles, then pulse frame_done and go to HOLD.
  - HOLD: refresh counter runs. If commit_pend, swap and go to FETCH. Otherwise, when the counter reaches REFRESH_CYC, go to FETCH without a swap (re-send the same front bank).
- After a swap, the back bank holds the previously displayed frame. The host rewrites whatever it wants changed.
- pix_data and pix_last are held stable while pix_valid=1 and pix_ready=0.
- A write and a commit in the same cycle: the write lands in the back bank before the swap, so it is displayed.
- A write in the same cycle as a swap targets the pre-swap back bank, so it is displayed.

## Timing

- Reset: pix_valid=0, pix_last=0, pix_data=0, busy=0, frame_done=0, front_sel=0, commit_pend=0, all counters 0, state IDLE. Bank contents are not reset (power-up 0 in sim).
- A reset mid-frame aborts the stream immediately: pix_valid drops on the next edge and no latch gap is generated.
- Latency from commit (in IDLE) to first pix_valid is 3 cycles: commit_pend set (+1), swap/FETCH (+2), valid (+3).
- SEND sustains one pixel per cycle when pix_ready is held high. The RAM read is registered with a next-address prefetch.
- The latch counter starts on entry to LATCH. frame_done is asserted RESET_CYC cycles after DRAIN exits and lasts exactly one cycle.
- The refresh counter clears on entry to HOLD and saturates at REFRESH_CYC. Counters are 32-bit, with no wrap.
- ser_idle is ignored outside DRAIN.

## Test plan

- Params CLK_FRE=1, LED_NUM=4, RESET_US=4, REFRESH_MS=1. Write pixels 0..3 = 24'h010203, 24'h0A0B0C, 24'hFF0000, 24'h0000FF, then commit with pix_ready=1, ser_idle=1. Required: 4 consecutive words in order, pix_last only on 24'h0000FF, frame_done 4 cycles after DRAIN exits.
- Same frame with pix_ready toggled 1,0,0,1,... Required: each word held stable through every stall, no word duplicated or skipped.
- Commit during SEND, then write pixel 1 = 24'h123456 and commit again. Required: the current frame is unaltered, exactly one swap at HOLD entry, and the next frame shows 24'h123456 at index 1.
- No commit after the first frame. Required: the identical frame is re-sent 1000 cycles after HOLD entry, with front_sel unchanged.
- Assert rst mid-SEND after 2 pixels. Required: next cycle pix_valid=0, busy=0, state IDLE, no frame_done. A following commit restarts from pixel 0.
- Write to wr_addr=5 (≥LED_NUM). Required: no bank change, and the stream after commit matches the prior contents.

Source files
------------

// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl
// Frame scheduler for a WS2812 chain. A double-buffered pixel store is written
// by the host; the front bank is streamed one 24-bit GRB word per LED to the
// bit serializer, followed by the latch (reset-low) gap. The displayed frame
// is re-sent on a fixed refresh period when no new frame has been committed.
//
// Handshake (pixel stream): pix_valid/pix_data/pix_last are presented by this
// block; a word is transferred on every rising edge where pix_valid && pix_ready.
// While pix_valid=1 and pix_ready=0, pix_data and pix_last are held stable and
// pix_valid is not withdrawn (except by rst, which aborts the stream).
module ws2812_frame_ctrl #(
  parameter int CLK_FRE    = 50,
  parameter int LED_NUM    = 8,
  parameter int RESET_US   = 300,
  parameter int REFRESH_MS = 200,
  parameter int AW         = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          commit,
  output logic          pix_valid,
  output logic [23:0]   pix_data,
  output logic          pix_last,
  input  logic          pix_ready,
  input  logic          ser_idle,
  output logic          busy,
  output logic          frame_done,
  output logic [2:0]    dbg_state,
  output logic          dbg_front_sel
);

  // Width of the internal pixel index (independent of the host address width,
  // which may be wider so that out-of-range addresses can be rejected).
  localparam int IW = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;

  localparam logic [31:0]   RESET_CYC   = 32'(CLK_FRE * RESET_US);
  localparam logic [31:0]   REFRESH_CYC = 32'(CLK_FRE * 1000 * REFRESH_MS);
  localparam logic [31:0]   LED_NUM_W   = 32'(LED_NUM);
  localparam logic [IW-1:0] LAST_IDX    = IW'(LED_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_DRAIN = 3'd3,
    S_LATCH = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            front_sel_q, front_sel_d;
  logic            commit_pend_q, commit_pend_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     lat_cnt_q, lat_cnt_d;
  logic [31:0]     ref_cnt_q, ref_cnt_d;
  logic            frame_done_q, frame_done_d;
  logic [23:0]     rd_data_q;

  logic            swap;
  logic            rd_load;
  logic [IW-1:0]   rd_addr;
  logic [23:0]     rd_word;
  logic            wr_hit;
  logic [IW-1:0]   wr_idx;

  // Bank contents are deliberately not reset.
  logic [23:0]     bank0 [LED_NUM];
  logic [23:0]     bank1 [LED_NUM];

  // Writes beyond the chain length are dropped; the index is narrowed only
  // after the range check so high address bits cannot alias onto a pixel.
  assign wr_hit = wr_en && (32'(wr_addr) < LED_NUM_W);
  assign wr_idx = IW'(wr_addr);

  // Host write port: always targets the back bank as seen before any swap on
  // this same edge, so a write coinciding with a swap ends up displayed.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      if (front_sel_q) begin
        bank0[wr_idx] <= wr_data;
      end else begin
        bank1[wr_idx] <= wr_data;
      end
    end
  end

  // Front-bank read mux feeding the registered read.
  always_comb begin
    rd_word = front_sel_q ? bank1[rd_addr] : bank0[rd_addr];
  end

  // State, bank selection, commit request and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      front_sel_q   <= 1'b0;
      commit_pend_q <= 1'b0;
      idx_q         <= '0;
      lat_cnt_q     <= '0;
      ref_cnt_q     <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      front_sel_q   <= front_sel_d;
      commit_pend_q <= commit_pend_d;
      idx_q         <= idx_d;
      lat_cnt_q     <= lat_cnt_d;
      ref_cnt_q     <= ref_cnt_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Registered pixel read: loaded with pixel 0 in FETCH and with the next
  // pixel on each accepted transfer, otherwise held for stall stability.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_load) begin
      rd_data_q <= rd_word;
    end
  end

  // Next-state logic: frame sequencing, prefetch address and counter updates.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lat_cnt_d    = lat_cnt_q;
    ref_cnt_d    = ref_cnt_q;
    frame_done_d = 1'b0;
    swap         = 1'b0;
    rd_load      = 1'b0;
    rd_addr      = idx_q;

    case (state_q)
      S_IDLE: begin
        if (commit_pend_q) begin
          swap    = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        idx_d   = '0;
        rd_addr = '0;
        rd_load = 1'b1;
        state_d = S_SEND;
      end

      S_SEND: begin
        if (pix_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DRAIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            rd_addr = idx_q + 1'b1;
            rd_load = 1'b1;
          end
        end
      end

      S_DRAIN: begin
        if (ser_idle) begin
          lat_cnt_d = '0;
          state_d   = S_LATCH;
        end
      end

      // LATCH occupies exactly RESET_CYC cycles; frame_done rises together
      // with the entry into HOLD.
      S_LATCH: begin
        lat_cnt_d = lat_cnt_q + 32'd1;
        if ((lat_cnt_q + 32'd1) >= RESET_CYC) begin
          frame_done_d = 1'b1;
          ref_cnt_d    = '0;
          state_d      = S_HOLD;
        end
      end

      // HOLD occupies REFRESH_CYC cycles before a refresh re-send, unless a
      // pending commit swaps banks first.
      S_HOLD: begin
        if (commit_pend_q) begin
          swap    = 1'b1;
          state_d = S_FETCH;
        end else if ((ref_cnt_q + 32'd1) >= REFRESH_CYC) begin
          state_d = S_FETCH;
        end else begin
          ref_cnt_d = (ref_cnt_q < REFRESH_CYC) ? ref_cnt_q + 32'd1 : ref_cnt_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    front_sel_d   = front_sel_q ^ swap;
    // A commit arriving on the swap edge is a fresh request and stays pending.
    commit_pend_d = commit | (commit_pend_q & ~swap);
  end

  // Output decode.
  always_comb begin
    pix_valid     = (state_q == S_SEND);
    pix_last      = (state_q == S_SEND) && (idx_q == LAST_IDX);
    pix_data      = rd_data_q;
    busy          = (state_q != S_IDLE) && (state_q != S_HOLD);
    frame_done    = frame_done_q;
    dbg_state     = state_q;
    dbg_front_sel = front_sel_q;
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Testbench for ws2812_frame_ctrl: host-level buffer model feeding an expected
// word queue, with an independent monitor that checks every accepted pixel,
// stall stability, latch gap and frame_done shape.
module tb_ws2812_frame_ctrl;

  localparam int LED_NUM     = 4;
  localparam int RESET_CYC   = 4;     // CLK_FRE=1 * RESET_US=4
  localparam int REFRESH_CYC = 1000;  // CLK_FRE=1 * 1000 * REFRESH_MS=1
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd4;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic        commit;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_last;
  logic        pix_ready;
  logic        ser_idle;
  logic        busy;
  logic        frame_done;
  logic [2:0]  dbg_state;
  logic        dbg_front_sel;

  ws2812_frame_ctrl #(
    .CLK_FRE(1), .LED_NUM(LED_NUM), .RESET_US(4), .REFRESH_MS(1), .AW(3)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_last(pix_last), .pix_ready(pix_ready), .ser_idle(ser_idle),
    .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state),
    .dbg_front_sel(dbg_front_sel)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [24:0] exp_q[$];          // {last, data}
  int checks = 0;
  int errors = 0;

  // Host-level model: two frame buffers, the host owns the one not displayed.
  logic [23:0] mbank [2][LED_NUM];
  logic        mfront = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < LED_NUM; i++)
      exp_q.push_back({(i == LED_NUM - 1), mbank[mfront][i]});
  endtask

  // The buffer the host filled becomes the displayed one.
  task automatic swap_push();
    mfront = ~mfront;
    push_frame();
  endtask

  // ---------------- monitor ----------------
  int          acc_n = 0;
  int          fd_count = 0;
  int          fd_cyc = 0;
  int          latch_start = 0;
  int          valid_rise_cyc = 0;
  int          last_span = -1;
  int          first_acc = 0;
  int          word_idx = 0;
  logic        prev_fd = 1'b0;
  logic        prev_valid = 1'b0;
  logic [2:0]  prev_state = 3'd0;
  logic        stall = 1'b0;
  logic [23:0] held_data = '0;
  logic        held_last = 1'b0;
  logic [24:0] e;

  always @(negedge clk) begin
    #1;
    if (pix_valid) chk("busy_with_valid", busy, 1);

    if (dbg_state == ST_LATCH && prev_state != ST_LATCH) latch_start = cyc;
    prev_state = dbg_state;

    if (frame_done) begin
      chk("frame_done_width", prev_fd, 0);
      chk("latch_gap", cyc - latch_start, RESET_CYC);
      fd_count++;
      fd_cyc = cyc;
    end
    prev_fd = frame_done;

    if (pix_valid && !prev_valid) valid_rise_cyc = cyc;
    prev_valid = pix_valid;

    if (stall && !rst) begin
      chk("stall_valid_held", pix_valid, 1);
      if (pix_valid) begin
        chk("stall_data_held", pix_data, held_data);
        chk("stall_last_held", pix_last, held_last);
      end
    end

    if (pix_valid && pix_ready && !rst) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h last %0b expected none (cycle %0d)",
                 pix_data, pix_last, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pix_data", pix_data, e[23:0]);
        chk("pix_last", pix_last, e[24]);
        if (word_idx == 0) first_acc = cyc;
        if (e[24]) begin
          last_span = cyc - first_acc;
          word_idx  = 0;
        end else begin
          word_idx++;
        end
      end
      acc_n++;
    end

    stall = pix_valid && !pix_ready && !rst;
    held_data = pix_data;
    held_last = pix_last;
  end

  // ---------------- driver ----------------
  int       ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0,1, 2: random
  int       idle_mode = 0;    // 0: serializer idle, 1: random idle
  bit [3:0] pat = 4'b1001;
  int       pat_i = 0;
  int       commit_cyc = 0;

  task automatic tick();
    @(negedge clk);
    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    commit  = 1'b0;
    case (ready_mode)
      0: pix_ready = 1'b1;
      1: begin pix_ready = pat[pat_i % 4]; pat_i++; end
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
    ser_idle = (idle_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
  endtask

  task automatic host_write(input int a, input logic [23:0] d);
    tick();
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    if (a < LED_NUM) mbank[~mfront][a] = d;
  endtask

  task automatic host_commit();
    tick();
    commit = 1'b1;
    commit_cyc = cyc;
  endtask

  task automatic wait_fd(input string name, input int budget);
    int start = fd_count;
    int n = 0;
    while (fd_count == start && n < budget) begin tick(); n++; end
    checks++;
    if (fd_count == start) begin
      errors++;
      $display("FAIL %s: got no frame_done expected one within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!pix_valid && n < budget) begin tick(); n++; end
    checks++;
    if (!pix_valid) begin
      errors++;
      $display("FAIL wait_valid: got pix_valid 0 expected 1 within %0d cycles", budget);
    end
  endtask

  // ---------------- main stimulus ----------------
  int          base;
  int          fd0;
  int          prev_fd_cyc;
  int          n;
  int          a;
  logic [23:0] d;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < LED_NUM; i++) mbank[b][i] = '0;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
    pix_ready = 1'b0; ser_idle = 1'b1;
    for (int k = 0; k < 2; k++) begin tick(); rst = 1'b1; end
    tick();

    // Reset values.
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_last", pix_last, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_front_sel", dbg_front_sel, 0);

    // Basic frame, always ready: latency, back-to-back words, latch gap.
    host_write(0, 24'h010203);
    host_write(1, 24'h0A0B0C);
    host_write(2, 24'hFF0000);
    host_write(3, 24'h0000FF);
    host_commit();
    swap_push();
    wait_fd("frame1_done", 100);
    chk("commit_latency", valid_rise_cyc - commit_cyc, 3);
    chk("burst_span", last_span, LED_NUM - 1);
    chk("front_sel_frame1", dbg_front_sel, mfront);
    chk("queue_drained_frame1", exp_q.size(), 0);

    // No commit: the same frame comes back after the refresh period.
    prev_fd_cyc = fd_cyc;
    push_frame();
    wait_fd("refresh_done", 1500);
    // HOLD lasts REFRESH_CYC cycles, FETCH one more, then pix_valid.
    chk("refresh_period", valid_rise_cyc - prev_fd_cyc, REFRESH_CYC + 1);
    chk("front_sel_refresh", dbg_front_sel, mfront);

    // Same frame with a stalling serializer.
    ready_mode = 1;
    host_write(0, 24'h010203);
    host_write(1, 24'h0A0B0C);
    host_write(2, 24'hFF0000);
    host_write(3, 24'h0000FF);
    host_commit();
    swap_push();
    wait_fd("stall_frame_done", 200);
    chk("front_sel_stall", dbg_front_sel, mfront);

    // Commit during SEND, then rewrite pixel 1 and commit again.
    for (int i = 0; i < LED_NUM; i++) host_write(i, 24'($urandom));
    host_commit();
    swap_push();
    wait_valid(50);
    tick();
    commit = 1'b1;
    host_write(1, 24'h123456);
    tick();
    commit = 1'b1;
    swap_push();
    wait_fd("inflight_frame_done", 200);
    wait_fd("next_frame_done", 200);
    chk("front_sel_single_swap", dbg_front_sel, mfront);
    chk("queue_drained_swap", exp_q.size(), 0);

    // Reset after two accepted pixels.
    ready_mode = 0;
    for (int i = 0; i < LED_NUM; i++) host_write(i, 24'($urandom));
    host_commit();
    swap_push();
    base = acc_n;
    n = 0;
    while (acc_n < base + 2 && n < 50) begin tick(); n++; end
    chk("abort_two_accepted", acc_n - base, 2);
    rst = 1'b1;
    pix_ready = 1'b0;
    fd0 = fd_count;
    tick();
    chk("abort_pix_valid", pix_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_state", dbg_state, ST_IDLE);
    chk("abort_front_sel", dbg_front_sel, 0);
    exp_q.delete();
    word_idx = 0;
    mfront = 1'b0;
    repeat (12) tick();
    chk("abort_no_frame_done", fd_count, fd0);
    host_commit();
    swap_push();
    wait_fd("restart_frame_done", 100);
    chk("restart_latency", valid_rise_cyc - commit_cyc, 3);
    chk("front_sel_restart", dbg_front_sel, mfront);

    // Out-of-range writes must not touch the bank.
    host_write(5, 24'($urandom));
    host_write(4, 24'($urandom));
    host_write(7, 24'($urandom));
    host_commit();
    swap_push();
    wait_fd("oor_frame_done", 100);

    // Random frames: random partial rewrites, last write shares the commit cycle.
    ready_mode = 2;
    idle_mode = 1;
    for (int f = 0; f < 5; f++) begin
      n = $urandom_range(1, 4);
      for (int w = 0; w < n - 1; w++) host_write($urandom_range(0, 7), 24'($urandom));
      tick();
      a = $urandom_range(0, 7);
      d = 24'($urandom);
      wr_en = 1'b1;
      wr_addr = 3'(a);
      wr_data = d;
      commit = 1'b1;
      if (a < LED_NUM) mbank[~mfront][a] = d;
      swap_push();
      wait_fd("random_frame_done", 300);
      chk("front_sel_random", dbg_front_sel, mfront);
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
